key_debounce_array: RTL and testbench
=====================================

# key_debounce_array

Parametrised multi-channel push-button conditioner: synchronises `NUM_KEYS` raw asynchronous key inputs and debounces each channel independently. Per channel it produces a debounced level plus single-cycle press, release, long-press and auto-repeat event pulses. It sits between the board push-buttons and the control/menu logic, which consumes events only, never raw levels.

## Interface
- `NUM_KEYS`, 4: number of independent key channels (≥1).
- `ACTIVE_LOW`, 1: 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (20 ms @ 50 MHz). Must be ≥2.
- `LONG_CYCLES`, 50_000_000: cycles from press event to long-press event (1 s). Must be ≥1.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat period after long-press. 0 disables repeat.

Ports:
- `I_clk` in 1: single system clock.
- `I_rst` in 1: synchronous, active-high reset.
- `I_key_in` in NUM_KEYS: raw asynchronous key pins.
- `o_key_level` out NUM_KEYS: debounced pressed level (1 = pressed).
- `o_key_press` out NUM_KEYS: 1-cycle pulse on accepted press.
- `o_key_release` out NUM_KEYS: 1-cycle pulse on accepted release.
- `o_key_long` out NUM_KEYS: 1-cycle pulse when hold reaches `LONG_CYCLES`.
- `o_key_repeat` out NUM_KEYS: 1-cycle pulse every `REPEAT_CYCLES` after long.

## Operation
- Per channel: 2-flop synchroniser. Reset value of the synchroniser is the idle pin level (`ACTIVE_LOW`). Internal `pressed_s = sync2 ^ ACTIVE_LOW`.
- Per-channel FSM, with states REL, P_CHK, PRS and R_CHK:
  - REL: on `pressed_s`=1, go to P_CHK; `db_cnt` <= 1.
  - P_CHK: if `pressed_s`=0, go to REL and clear `db_cnt`. Else if `db_cnt`==DEBOUNCE_CYCLES-1, go to PRS, assert press, clear `db_cnt` and `hold_cnt`. Else increment `db_cnt`.
  - PRS: on `pressed_s`=0, go to R_CHK; `db_cnt` <= 1.
  - R_CHK: if `pressed_s`=1, return to PRS and clear `db_cnt`. Else if `db_cnt`==DEBOUNCE_CYCLES-1, go to REL and assert release. Else increment `db_cnt`.
- `o_key_level` = 1 in PRS and R_CHK; 0 in REL and P_CHK.
- `hold_cnt` increments each cycle in PRS and R_CHK, saturating at LONG_CYCLES. Bounces into R_CHK do not clear it.
- Long-press: `o_key_long` pulses on the edge where `hold_cnt` becomes LONG_CYCLES. It fires at most once per press.
- Repeat: after the long-press pulse, `rep_cnt` counts 1..REPEAT_CYCLES and `o_key_repeat` pulses each time it wraps. With REPEAT_CYCLES=0, `o_key_repeat` stays 0.
- Counter widths are `$clog2(param+1)`. No counter ever wraps: `hold_cnt` saturates and `rep_cnt` reloads.
- Channels are fully independent. Any combination of pulses may assert on different channels in the same cycle.

## Timing
- Reset, on any cycle with `I_rst`=1:
  - All outputs 0 on the next edge.
  - FSM goes to REL; all counters 0; synchronisers go to idle level.
  - Reset mid-debounce or mid-hold discards in-progress state and emits no release pulse.
- Press latency:
  - Raw change first sampled at edge 0 and held → `o_key_level` and `o_key_press` registered at edge DEBOUNCE_CYCLES+1.
  - Release latency is identical.
- Any bounce restarts the debounce window. Acceptance requires DEBOUNCE_CYCLES consecutive cycles of `pressed_s` at the new level.
- Event timing, with the press pulse at edge P:
  - Long pulse at edge P+LONG_CYCLES.
  - Repeat pulses at P+LONG_CYCLES+k·REPEAT_CYCLES, for k ≥ 1.
- Release has priority. On the edge R_CHK→REL, the long and repeat pulses are suppressed even if their counter reaches its terminal value on that edge.
- A key held through reset deassertion is reported as a press at edge DEBOUNCE_CYCLES+1 after the first non-reset edge.
- All outputs are registered; there are no combinational paths from `I_key_in`.

## Test plan
Bench parameters: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=10.
- **Clean press:** `I_key_in[0]` 1→0 sampled at edge 0 and held → `o_key_level[0]`=1 and a single `o_key_press[0]` pulse at edge 9; channel 1 outputs stay 0.
- **Bounce:** `I_key_in[0]` low 7 cycles, high 1 cycle, then low → no press until 8 consecutive low cycles; press at last-low-start edge +9.
- **Long and repeat:** hold 100 cycles after the press at edge P → `o_key_long` at P+40; `o_key_repeat` at P+50, P+60, P+70, …; release → `o_key_release` 9 edges after the pin goes high; no further repeats.
- **Short press:** hold 20 cycles after press then release → press and release pulses only; `o_key_long` and `o_key_repeat` never assert.
- **Reset:** assert `I_rst` 5 cycles into R_CHK → all outputs 0 next edge, no release pulse. Deassert with key held → press at edge 9 after deassertion.
- **Simultaneous:** both pins pressed at the same edge → `o_key_press`=2'b11 in the same cycle; release ch1 only → `o_key_release`=2'b10, and ch0 long still fires at P+40.

Source files
------------

// File: rtl/key_debounce_array.sv
// key_debounce_array: per-channel 2-flop synchroniser and debounce FSM
// producing a debounced level plus press, release, long-press and
// auto-repeat single-cycle event pulses. All outputs are registered.
module key_debounce_array #(
    parameter int NUM_KEYS        = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic [NUM_KEYS-1:0] I_key_in,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_long,
    output logic [NUM_KEYS-1:0] o_key_repeat
);

    localparam logic IDLE   = (ACTIVE_LOW != 0);
    localparam int   DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   HOLD_W = $clog2(LONG_CYCLES + 1);
    // A zero repeat period still needs a legal (1-bit) counter.
    localparam int   REP_W  = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        REL,
        P_CHK,
        PRS,
        R_CHK
    } key_state_t;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic [1:0]        sync_q;
        logic              pressed_s;
        key_state_t        state_q;
        logic [DB_W-1:0]   db_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic [REP_W-1:0]  rep_cnt;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              repeat_q;
        logic              release_edge;
        logic              hold_adv;

        // Two-flop synchroniser, idling at the unpressed pin level.
        always_ff @(posedge I_clk) begin
            if (I_rst) begin
                sync_q <= {2{IDLE}};
            end else begin
                sync_q <= {sync_q[0], I_key_in[g]};
            end
        end

        assign pressed_s = sync_q[1] ^ IDLE;

        // Hold timing advances while held, except on the accepted-release edge.
        always_comb begin
            release_edge = (state_q == R_CHK) && !pressed_s && (db_cnt == DB_LAST);
            hold_adv     = ((state_q == PRS) || (state_q == R_CHK)) && !release_edge;
        end

        // Debounce FSM with registered level and event pulses.
        always_ff @(posedge I_clk) begin
            if (I_rst) begin
                state_q   <= REL;
                db_cnt    <= '0;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;

                case (state_q)
                    REL: begin
                        if (pressed_s) begin
                            state_q <= P_CHK;
                            db_cnt  <= DB_ONE;
                        end
                    end
                    P_CHK: begin
                        if (!pressed_s) begin
                            state_q <= REL;
                            db_cnt  <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state_q  <= PRS;
                            press_q  <= 1'b1;
                            level_q  <= 1'b1;
                            db_cnt   <= '0;
                            hold_cnt <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    PRS: begin
                        if (!pressed_s) begin
                            state_q <= R_CHK;
                            db_cnt  <= DB_ONE;
                        end
                    end
                    R_CHK: begin
                        if (pressed_s) begin
                            state_q <= PRS;
                            db_cnt  <= '0;
                        end else if (db_cnt == DB_LAST) begin
                            state_q   <= REL;
                            release_q <= 1'b1;
                            level_q   <= 1'b0;
                            db_cnt    <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= REL;
                        db_cnt  <= '0;
                    end
                endcase

                // A saturated hold counter marks that the long pulse already fired,
                // which is what enables the repeat counter.
                if (hold_adv) begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == HOLD_LAST) begin
                            long_q  <= 1'b1;
                            rep_cnt <= REP_ONE;
                        end
                    end else if (REPEAT_CYCLES != 0) begin
                        if (rep_cnt == REP_MAX) begin
                            repeat_q <= 1'b1;
                            rep_cnt  <= REP_ONE;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
            end
        end

        assign o_key_level[g]   = level_q;
        assign o_key_press[g]   = press_q;
        assign o_key_release[g] = release_q;
        assign o_key_long[g]    = long_q;
        assign o_key_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// tb_key_debounce_array: scoreboard bench. Each scenario pushes the edge
// number at which every event is expected; the stepper pops entries due on
// the current edge and each scenario compares all outputs every cycle.
module tb_key_debounce_array;

    localparam int NK = 2;

    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_LONG  = 2;
    localparam int EV_REP   = 3;
    localparam int EV_CLR   = 4;

    typedef struct {
        int at;
        int kind;
        int ch;
    } ev_t;

    logic          I_clk = 1'b0;
    logic          I_rst = 1'b1;
    logic [NK-1:0] keys  = '1;
    logic [NK-1:0] o_key_level;
    logic [NK-1:0] o_key_press;
    logic [NK-1:0] o_key_release;
    logic [NK-1:0] o_key_long;
    logic [NK-1:0] o_key_repeat;

    int            edge_no = 0;
    int            n_tests = 0;
    int            n_fail  = 0;
    ev_t           sb[$];
    logic [NK-1:0] exp_level = '0;
    logic [5*NK-1:0] got;
    logic [5*NK-1:0] want;

    key_debounce_array #(
        .NUM_KEYS       (NK),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(8),
        .LONG_CYCLES    (40),
        .REPEAT_CYCLES  (10)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_key_in     (keys),
        .o_key_level  (o_key_level),
        .o_key_press  (o_key_press),
        .o_key_release(o_key_release),
        .o_key_long   (o_key_long),
        .o_key_repeat (o_key_repeat)
    );

    always #5 I_clk = ~I_clk;

    // Edge index: value seen at a negedge is the number of the edge just taken.
    always @(posedge I_clk) edge_no <= edge_no + 1;

    task automatic push(input int at, input int kind, input int ch);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    // Advance to the next negedge and build the expected output word.
    task automatic step();
        logic [NK-1:0] wp, wr, wl, wq;
        @(negedge I_clk);
        wp = '0;
        wr = '0;
        wl = '0;
        wq = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_no) begin
                case (sb[i].kind)
                    EV_PRESS: begin wp[sb[i].ch] = 1'b1; exp_level[sb[i].ch] = 1'b1; end
                    EV_REL:   begin wr[sb[i].ch] = 1'b1; exp_level[sb[i].ch] = 1'b0; end
                    EV_LONG:  wl[sb[i].ch] = 1'b1;
                    EV_REP:   wq[sb[i].ch] = 1'b1;
                    default:  exp_level = '0;
                endcase
                sb.delete(i);
            end
        end
        want = {exp_level, wp, wr, wl, wq};
        got  = {o_key_level, o_key_press, o_key_release, o_key_long, o_key_repeat};
    endtask

    task automatic test_reset();
        I_rst = 1'b1;
        keys  = '1;
        for (int c = 1; c <= 24; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset edge %0d: got %b want %b", edge_no, got, want);
            end
            if (c == 4) I_rst = 1'b0;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_clean_press();
        int b;
        b = edge_no;
        keys[0] = 1'b0;
        push(b + 10, EV_PRESS, 0);
        for (int c = 1; c <= 35; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: got %b want %b", edge_no, got, want);
            end
            if (edge_no == b + 15) begin
                keys[0] = 1'b1;
                push(b + 25, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL clean_press_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_bounce();
        int b;
        b = edge_no;
        keys[0] = 1'b0;
        push(b + 18, EV_PRESS, 0);
        for (int c = 1; c <= 45; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bounce edge %0d: got %b want %b", edge_no, got, want);
            end
            if (edge_no == b + 7) keys[0] = 1'b1;
            if (edge_no == b + 8) keys[0] = 1'b0;
            if (edge_no == b + 22) begin
                keys[0] = 1'b1;
                push(b + 32, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_long_repeat();
        int p;
        p = edge_no + 10;
        keys[0] = 1'b0;
        push(p, EV_PRESS, 0);
        push(p + 40, EV_LONG, 0);
        for (int k = 1; k <= 6; k++) push(p + 40 + 10 * k, EV_REP, 0);
        for (int c = 1; c <= 140; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL long_repeat edge %0d: got %b want %b", edge_no, got, want);
            end
            // Release lands on a repeat boundary: the repeat must be suppressed.
            if (edge_no == p + 100) begin
                keys[0] = 1'b1;
                push(p + 110, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL long_repeat_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_short_press();
        int p;
        p = edge_no + 10;
        keys[0] = 1'b0;
        push(p, EV_PRESS, 0);
        for (int c = 1; c <= 70; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL short_press edge %0d: got %b want %b", edge_no, got, want);
            end
            if (edge_no == p + 20) begin
                keys[0] = 1'b1;
                push(p + 30, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL short_press_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_release();
        int p;
        int m;
        p = edge_no + 10;
        m = p + 5;
        keys[0] = 1'b0;
        push(p, EV_PRESS, 0);
        for (int c = 1; c <= 50; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: got %b want %b", edge_no, got, want);
            end
            if (edge_no == m) keys[0] = 1'b1;
            // Five cycles into R_CHK: reset, with the key pressed again.
            if (edge_no == m + 8) begin
                I_rst   = 1'b1;
                keys[0] = 1'b0;
                push(m + 9, EV_CLR, 0);
            end
            if (edge_no == m + 11) begin
                I_rst = 1'b0;
                push(m + 21, EV_PRESS, 0);
            end
            if (edge_no == m + 25) begin
                keys[0] = 1'b1;
                push(m + 35, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_sb: %0d events left, want 0", sb.size());
        end
    endtask

    task automatic test_simultaneous();
        int p;
        p = edge_no + 10;
        keys = 2'b00;
        push(p, EV_PRESS, 0);
        push(p, EV_PRESS, 1);
        push(p + 40, EV_LONG, 0);
        push(p + 50, EV_REP, 0);
        push(p + 60, EV_REP, 0);
        for (int c = 1; c <= 85; c++) begin
            step();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: got %b want %b", edge_no, got, want);
            end
            if (edge_no == p + 15) begin
                keys[1] = 1'b1;
                push(p + 25, EV_REL, 1);
            end
            if (edge_no == p + 52) begin
                keys[0] = 1'b1;
                push(p + 62, EV_REL, 0);
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL simultaneous_sb: %0d events left, want 0", sb.size());
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_short_press();
        test_reset_mid_release();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
